// File: rtl/fpcvt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpcvt_pkg : shared widths, state encoding and constants for fpcvt blocks  |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
package fpcvt_pkg;

  localparam int FPCVT_D_W = 12;
  localparam int FPCVT_E_W = 3;
  localparam int FPCVT_F_W = 5;

  // Largest exponent; also the initial normalisation exponent.
  localparam logic [FPCVT_E_W-1:0] E_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABS   = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rounder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rounder : round-half-up of a truncated significand using the sixth bit   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module rounder #(
  parameter int E_W = 3,
  parameter int F_W = 5
) (
  input  logic [E_W-1:0] E_in,
  input  logic [F_W-1:0] F_in,
  input  logic           Sixth,
  output logic [E_W-1:0] E_out,
  output logic [F_W-1:0] F_out
);

  logic [F_W:0] w_sum;

  always_comb begin
    w_sum = {1'b0, F_in} + {{F_W{1'b0}}, Sixth};
    // A carry out renormalises: significand becomes 100..0 and exponent steps up.
    if (w_sum[F_W]) begin
      F_out = {1'b1, {(F_W-1){1'b0}}};
      E_out = E_in + 1'b1;
    end else begin
      F_out = w_sum[F_W-1:0];
      E_out = E_in;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpcvt_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpcvt_seq_ctrl : sequential two's-complement to {S,E,F} float converter  |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module fpcvt_seq_ctrl
  import fpcvt_pkg::*;
#(
  parameter int D_W = FPCVT_D_W,
  parameter int E_W = FPCVT_E_W,
  parameter int F_W = FPCVT_F_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D_W-1:0] D,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           S,
  output logic [E_W-1:0] E,
  output logic [F_W-1:0] F,
  output logic           busy
);

  localparam logic [E_W-1:0] C_E_MAX  = '1;
  localparam logic [F_W-1:0] C_F_ONES = '1;
  localparam logic [D_W-1:0] C_D_MIN  = {1'b1, {(D_W-1){1'b0}}};
  localparam logic [D_W-1:0] C_D_MAX  = {1'b0, {(D_W-1){1'b1}}};

  state_t         r_state;
  logic [D_W-1:0] r_d;
  logic [D_W-1:0] r_mag;
  logic [E_W-1:0] r_e;

  logic [D_W-1:0] w_abs;
  logic [F_W-1:0] w_f_in;
  logic           w_sixth;
  logic [E_W-1:0] w_e_out;
  logic [F_W-1:0] w_f_out;
  logic           w_sat;

  // The most negative word has no positive twin, so it clamps to the largest magnitude.
  assign w_abs = !r_d[D_W-1] ? r_d :
                 (r_d == C_D_MIN) ? C_D_MAX : (~r_d + 1'b1);

  assign w_f_in  = r_mag[D_W-1 -: F_W];
  assign w_sixth = r_mag[D_W-1-F_W];
  assign w_sat   = (r_e == C_E_MAX) && (w_f_in == C_F_ONES) && w_sixth;

  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

  rounder #(
    .E_W (E_W),
    .F_W (F_W)
  ) u_rounder (
    .E_in  (r_e),
    .F_in  (w_f_in),
    .Sixth (w_sixth),
    .E_out (w_e_out),
    .F_out (w_f_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_d       <= '0;
      r_mag     <= '0;
      r_e       <= '0;
      out_valid <= 1'b0;
      S         <= 1'b0;
      E         <= '0;
      F         <= '0;
    end else if (clear) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_d     <= D;
            r_state <= ABS;
          end
        end
        ABS: begin
          S       <= r_d[D_W-1];
          r_mag   <= w_abs;
          r_e     <= C_E_MAX;
          r_state <= NORM;
        end
        NORM: begin
          if (!r_mag[D_W-1] && (r_e != '0)) begin
            r_mag <= r_mag << 1;
            r_e   <= r_e - 1'b1;
          end else begin
            r_state <= ROUND;
          end
        end
        ROUND: begin
          // Rounding up at the top exponent would wrap; clamp to the largest value instead.
          if (w_sat) begin
            E <= C_E_MAX;
            F <= C_F_ONES;
          end else begin
            E <= w_e_out;
            F <= w_f_out;
          end
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fpcvt_seq_ctrl : scoreboard bench for the sequential float converter  |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_fpcvt_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] D = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        S;
  logic [2:0]  E;
  logic [4:0]  F;
  logic        busy;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [4:0] f;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  fpcvt_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pops on each rising out_valid, re-checks the held value at the handshake.
  exp_t cur;
  logic have_cur = 1'b0;
  logic prev_ov  = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov  = 1'b0;
        have_cur = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            cur = sb.pop_front();
            chk("S", int'(S), int'(cur.s));
            chk("E", int'(E), int'(cur.e));
            chk("F", int'(F), int'(cur.f));
            chk("latency", cyc - cur.acc, cur.lat);
            have_cur = 1'b1;
          end
        end
        if (out_valid && out_ready && have_cur) begin
          chk("held_SEF", int'({S, E, F}), int'({cur.s, cur.e, cur.f}));
          have_cur = 1'b0;
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic start(input logic [11:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    D        = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy || out_valid) chk("idle_timeout", 0, 1);
  endtask

  task automatic convert(input logic [11:0] d, input logic s, input logic [2:0] e,
                         input logic [4:0] f, input int lat);
    exp_t x;
    start(d);
    x.s = s; x.e = e; x.f = f; x.lat = lat; x.acc = acc_cyc;
    sb.push_back(x);
    wait_idle();
  endtask

  initial begin
    exp_t x;
    int   n;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_SEF", int'({S, E, F}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    convert(12'h000, 1'b0, 3'b000, 5'b00000, 10);
    convert(12'h7FF, 1'b0, 3'b111, 5'b10000, 4);
    convert(12'h800, 1'b1, 3'b111, 5'b10000, 4);
    convert(12'h07E, 1'b0, 3'b011, 5'b10000, 8);
    convert(12'hFE6, 1'b1, 3'b000, 5'b11010, 10);
    convert(12'h400, 1'b0, 3'b110, 5'b10000, 4);
    convert(12'hFFF, 1'b1, 3'b000, 5'b00001, 10);
    convert(12'h0C0, 1'b0, 3'b011, 5'b11000, 7);
    convert(12'h3F0, 1'b0, 3'b110, 5'b10000, 5);
    convert(12'h3E0, 1'b0, 3'b101, 5'b11111, 5);

    // Backpressure: result must sit still while the consumer stalls.
    @(negedge clk);
    out_ready = 1'b0;
    start(12'h01A);
    x.s = 1'b0; x.e = 3'b000; x.f = 5'b11010; x.lat = 10; x.acc = acc_cyc;
    sb.push_back(x);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_held_SEF", int'({S, E, F}), int'({1'b0, 3'b000, 5'b11010}));
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);

    // Asynchronous reset in the middle of normalisation.
    start(12'h07E);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_E", int'(E), 0);
    chk("arst_F", int'(F), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Synchronous clear in the middle of normalisation: no result may appear.
    start(12'h000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_in_ready", int'(in_ready), 1);
    chk("clr_busy", int'(busy), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("clr_no_out_valid", int'(out_valid), 0);

    convert(12'h07E, 1'b0, 3'b011, 5'b10000, 8);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
